// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, control ranks
// and the per-edge control decoder.
package timer_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_HOLD = HOLD
   } state_e;

   // Control ranks: a higher value wins when several controls arrive on one edge.
   localparam logic [2:0] PRIO_STEP  = 3'd0;
   localparam logic [2:0] PRIO_START = 3'd1;
   localparam logic [2:0] PRIO_PAUSE = 3'd2;
   localparam logic [2:0] PRIO_STOP  = 3'd3;
   localparam logic [2:0] PRIO_LOAD  = 3'd4;

   typedef enum logic [2:0] {
      CMD_NONE  = PRIO_STEP,
      CMD_START = PRIO_START,
      CMD_PAUSE = PRIO_PAUSE,
      CMD_STOP  = PRIO_STOP,
      CMD_LOAD  = PRIO_LOAD
   } cmd_e;

   function automatic cmd_e decode_cmd(input logic i_load, input logic i_stop,
                                       input logic i_pause, input logic i_start);
      cmd_e w_cmd;
      if (i_load)       w_cmd = CMD_LOAD;
      else if (i_stop)  w_cmd = CMD_STOP;
      else if (i_pause) w_cmd = CMD_PAUSE;
      else if (i_start) w_cmd = CMD_START;
      else              w_cmd = CMD_NONE;
      return w_cmd;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running tick counter 0..PRESCALE-1 with synchronous clear and enable;
// o_tick flags the last count so the caller can step on the wrap edge.
module timer_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         if (r_cnt == LAST) r_cnt <= '0;
         else               r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Presettable down-counting timer with pause/resume/abort and auto-reload.
// Define TIMER_PRESCALE_EN to make each decrement step last PRESCALE clocks.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int NBITS    = 8,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [NBITS-1:0] data,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             reload_en,
   output logic [NBITS-1:0] count,
   output logic             busy,
   output logic             done
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("countdown_timer: PRESCALE must be >= 1");
   end

   state_e           r_state;
   state_e           w_state_next;
   logic [NBITS-1:0] r_count;
   logic [NBITS-1:0] w_count_next;
   logic [NBITS-1:0] r_reload;
   logic [NBITS-1:0] w_reload_next;
   logic             r_done;
   logic             w_done_next;
   logic             r_busy;
   logic             w_tick_clear;
   logic             w_tick_en;
   logic             w_step;
   cmd_e             w_cmd;

`ifdef TIMER_PRESCALE_EN
   logic w_tick;

   timer_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_tick_clear),
      .i_enable (w_tick_en),
      .o_tick   (w_tick)
   );

   assign w_step = w_tick;
`else
   assign w_step = 1'b1;
`endif

   assign w_cmd = decode_cmd(load, stop, pause, start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_count  <= w_count_next;
         r_reload <= w_reload_next;
         r_done   <= w_done_next;
         r_busy   <= (w_state_next != ST_IDLE);
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_reload_next = r_reload;
      w_done_next   = 1'b0;
      w_tick_clear  = 1'b0;
      w_tick_en     = 1'b0;

      unique case (w_cmd)
         CMD_LOAD: begin
            w_count_next  = data;
            w_reload_next = data;
            w_state_next  = ST_IDLE;
            w_tick_clear  = 1'b1;
         end
         CMD_STOP: begin
            w_state_next = ST_IDLE;
            w_tick_clear = 1'b1;
         end
         CMD_PAUSE: begin
            if (r_state == ST_RUN) w_state_next = ST_HOLD;
         end
         default: begin
            // CMD_START or CMD_NONE; start while running just lets the count continue.
            unique case (r_state)
               ST_IDLE: begin
                  if (w_cmd == CMD_START) begin
                     if (r_count != '0) begin
                        w_state_next = ST_RUN;
                        w_tick_clear = 1'b1;
                     end else begin
                        w_done_next = 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  if (w_cmd == CMD_START) w_state_next = ST_RUN;
               end
               ST_RUN: begin
                  w_tick_en = 1'b1;
                  if (r_count == '0) begin
                     w_state_next = ST_IDLE;
                  end else if (w_step) begin
                     if (r_count != NBITS'(1)) begin
                        w_count_next = r_count - 1'b1;
                     end else if (reload_en && (r_reload != '0)) begin
                        w_count_next = r_reload;
                        w_done_next  = 1'b1;
                     end else begin
                        w_count_next = '0;
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                     end
                  end
               end
               default: begin
                  w_state_next = ST_IDLE;
               end
            endcase
         end
      endcase
   end

   assign count = r_count;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Presettable down-counting timer, the decrementing counterpart of the team's modulus up-counter. It loads a start value, counts down one step per enabled cycle, and reports terminal count with a one-cycle done pulse. Auto-reload makes it a periodic tick generator. Pause, resume and abort controls are included. It sits beside the up-counters in the timing and control datapath.

Parameters:
NBITS, 8, width of count, data and reload register.
PRESCALE, 4, clocks per decrement step; used only when TIMER_PRESCALE_EN is defined; must be >= 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
load  in  1  load data into count and reload register; state goes to IDLE
data  in  NBITS  load value
start  in  1  begin a countdown from IDLE, or resume from HOLD
pause  in  1  freeze an active countdown (RUN -> HOLD)
stop  in  1  abort to IDLE; count keeps its current value
reload_en  in  1  on terminal count, reload and keep running
count  out  NBITS  current value, registered
busy  out  1  high in RUN and HOLD
done  out  1  one-cycle registered pulse on terminal count

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, reload_reg=0, done=0, busy=0. All outputs are registered.
- FSM states: IDLE, RUN, HOLD.
- Control priority per edge: load > stop > pause > start > decrement.
- load, in any state: count<=data, reload_reg<=data, state<=IDLE, done<=0.
- stop, in RUN or HOLD: state<=IDLE, count is held. stop in IDLE has no effect.
- pause in RUN: state<=HOLD, count is held. pause in IDLE or HOLD is ignored.
- start in IDLE:
  - count!=0: state<=RUN. The first decrement happens on the next edge, not on the start edge.
  - count==0: done<=1 for one cycle, state stays IDLE.
- start in HOLD: state<=RUN. start in RUN is ignored.
- RUN with no higher-priority control asserted:
  - count>1: count<=count-1.
  - count==1 and reload_en=0: count<=0, done<=1, state<=IDLE.
  - count==1 and reload_en=1: count<=reload_reg, done<=1, state stays RUN, giving period = reload_reg steps.
  - If reload_reg==0, reload_en is treated as 0 and the FSM goes to IDLE.
- Latency: a load of N followed by start produces done N edges after the start edge.
- done is never high for two consecutive cycles, except on back-to-back reloads with reload_reg==1.
- Arithmetic: modulo-2^NBITS. count never underflows, because 0 is never decremented.
- busy = (state==RUN || state==HOLD), registered alongside the state.

Optional Feature:
TIMER_PRESCALE_EN
- Defined:
  - An internal tick counter (0..PRESCALE-1) advances only in RUN; a decrement step happens only on its wrap.
  - The tick counter clears on reset, load, stop and start-from-IDLE; it is held in HOLD.
  - load N then start gives done after N*PRESCALE edges.
- Undefined: every RUN cycle is a step and PRESCALE is ignored.

Decomposition:
- Shared package timer_pkg holds the state encoding as localparams (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and the control-priority constants.
- One sub-module, timer_prescaler (tick counter with clear/enable, tick output), instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- Reset mid-RUN (count=5): rst_n low asynchronously -> count=0, busy=0, done=0 immediately, before the next clk edge.
- load data=3, start, no reload -> count goes 3,2,1,0 on successive edges; done high exactly on the edge count becomes 0; busy drops with it; state IDLE.
- load 4, reload_en=1, start, run 12 edges -> done pulses on the 4th, 8th and 12th edge after start; count sequence repeats 3,2,1,4.
- load 6, start, 2 steps, pause for 5 cycles, then start -> count holds 4 during the pause and continues 3,2,1,0; done fires once.
- Simultaneous load=1 (data=9), stop=1, start=1 while in RUN -> count=9, state IDLE, done=0 (load wins). Separately, start with count==0 -> single done pulse, busy stays 0.
- With TIMER_PRESCALE_EN and PRESCALE=4: load 2, start -> done 8 edges after start; pause mid-prescale, resume -> total active cycles still 8.
